// File: rtl/swc_rtu_rsp_fifo.sv
// Per-port FWFT buffer for RTU forwarding decisions feeding the core's rtu_rsp valid/ack interface.
// Optional statistics ports (overflow counter, high-water mark) are enabled by SWC_RTU_RSP_FIFO_STATS_EN.
module swc_rtu_rsp_fifo #(
  parameter int g_num_ports  = 8,
  parameter int g_prio_width = 3,
  parameter int g_depth      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          rtu_valid_i,
  input  logic [g_num_ports-1:0]        rtu_dst_port_mask_i,
  input  logic                          rtu_drop_i,
  input  logic [g_prio_width-1:0]       rtu_prio_i,
  output logic                          rtu_full_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ack_i,
  output logic [g_num_ports-1:0]        rsp_dst_port_mask_o,
  output logic                          rsp_drop_o,
  output logic [g_prio_width-1:0]       rsp_prio_o,
`ifdef SWC_RTU_RSP_FIFO_STATS_EN
  output logic [15:0]                   overflow_cnt_o,
  output logic [$clog2(g_depth):0]      max_level_o,
`endif
  output logic [$clog2(g_depth):0]      level_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(g_depth);
  localparam int CW = AW + 1;
  localparam int EW = g_num_ports + 1 + g_prio_width;

  logic [EW-1:0] r_mem [g_depth];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_valid;
  logic          w_rd_en;
  logic          w_wr_en;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == CW'(g_depth));
  assign w_valid = (r_count != '0);
  assign w_rd_en = rsp_ack_i & w_valid;
  // A full FIFO still accepts a decision when the head retires in the same cycle.
  assign w_wr_en = rtu_valid_i & (~w_full | w_rd_en);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= rtu_valid_i & ~w_wr_en;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_en && !w_rd_en)      r_count <= r_count + 1'b1;
      else if (w_rd_en && !w_wr_en) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty-state outputs are masked instead.
  always_ff @(posedge clk_i) begin
    if (w_wr_en && !flush_i)
      r_mem[r_wr_ptr] <= {rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i};
  end

  assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

  assign rsp_dst_port_mask_o = w_head[EW-1 -: g_num_ports];
  assign rsp_drop_o          = w_head[g_prio_width];
  assign rsp_prio_o          = w_head[g_prio_width-1:0];
  assign rsp_valid_o         = w_valid;
  assign rtu_full_o          = w_full;
  assign level_o             = r_count;
  assign overflow_o          = r_overflow;

`ifdef SWC_RTU_RSP_FIFO_STATS_EN
  logic [15:0]   r_overflow_cnt;
  logic [CW-1:0] r_max_level;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_overflow_cnt <= '0;
      r_max_level    <= '0;
    end else if (flush_i) begin
      r_overflow_cnt <= '0;
      r_max_level    <= '0;
    end else begin
      if (r_overflow && r_overflow_cnt != 16'hFFFF) r_overflow_cnt <= r_overflow_cnt + 1'b1;
      if (r_count > r_max_level)                    r_max_level    <= r_count;
    end
  end

  assign overflow_cnt_o = r_overflow_cnt;
  assign max_level_o    = r_max_level;
`endif

endmodule

// File: tb/tb_swc_rtu_rsp_fifo.sv
// Scoreboard bench for swc_rtu_rsp_fifo: stimulus pushes accepted decisions, a negedge monitor checks heads on ack.
module tb_swc_rtu_rsp_fifo;

  localparam int NP = 8;
  localparam int PW = 3;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          rtu_valid = 1'b0;
  logic [NP-1:0] rtu_mask = '0;
  logic          rtu_drop = 1'b0;
  logic [PW-1:0] rtu_prio = '0;
  logic          rtu_full;
  logic          rsp_valid;
  logic          rsp_ack = 1'b0;
  logic [NP-1:0] rsp_mask;
  logic          rsp_drop;
  logic [PW-1:0] rsp_prio;
  logic [CW-1:0] level;
  logic          overflow;
`ifdef SWC_RTU_RSP_FIFO_STATS_EN
  logic [15:0]   overflow_cnt;
  logic [CW-1:0] max_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;
  logic [NP+PW:0] sb_q [$];

  always #5 clk = ~clk;

  swc_rtu_rsp_fifo #(.g_num_ports(NP), .g_prio_width(PW), .g_depth(D)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .flush_i             (flush),
    .rtu_valid_i         (rtu_valid),
    .rtu_dst_port_mask_i (rtu_mask),
    .rtu_drop_i          (rtu_drop),
    .rtu_prio_i          (rtu_prio),
    .rtu_full_o          (rtu_full),
    .rsp_valid_o         (rsp_valid),
    .rsp_ack_i           (rsp_ack),
    .rsp_dst_port_mask_o (rsp_mask),
    .rsp_drop_o          (rsp_drop),
    .rsp_prio_o          (rsp_prio),
`ifdef SWC_RTU_RSP_FIFO_STATS_EN
    .overflow_cnt_o      (overflow_cnt),
    .max_level_o         (max_level),
`endif
    .level_o             (level),
    .overflow_o          (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake that retires an entry must match the oldest expected decision.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ack && !flush) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL head_unexpected: got 0x%0h expected none", {rsp_mask, rsp_drop, rsp_prio});
      end else begin
        logic [NP+PW:0] exp_e;
        exp_e = sb_q.pop_front();
        if ({rsp_mask, rsp_drop, rsp_prio} !== exp_e) begin
          n_fail++;
          $display("FAIL head_data: got 0x%0h expected 0x%0h", {rsp_mask, rsp_drop, rsp_prio}, exp_e);
        end
      end
    end
  end

  // One clock of stimulus; inputs change #1 after the edge and are held through the next edge.
  task automatic step(input logic v, input logic [NP-1:0] m, input logic d, input logic [PW-1:0] p,
                      input logic ack, input logic fl);
    logic rd, wr;
    rtu_valid = v; rtu_mask = m; rtu_drop = d; rtu_prio = p; rsp_ack = ack; flush = fl;
    rd = ack && (model_cnt > 0);
    wr = v && ((model_cnt < D) || rd);
    if (!fl) begin
      if (wr) sb_q.push_back({m, d, p});
      model_cnt = model_cnt + int'(wr) - int'(rd);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb_q.delete();
      model_cnt = 0;
    end
    rtu_valid = 1'b0; rsp_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (rsp_valid && guard < 3 * D) begin
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    check({name, "_drained_level"}, 32'(level), 32'd0);
    check({name, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_full", 32'(rtu_full), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_data", 32'({rsp_mask, rsp_drop, rsp_prio}), 32'd0);

    // Single decision
    step(1'b1, 8'h05, 1'b0, 3'd3, 1'b0, 1'b0);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_mask", 32'(rsp_mask), 32'h05);
    check("single_prio", 32'(rsp_prio), 32'd3);
    check("single_level", 32'(level), 32'd1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check("single_ack_valid", 32'(rsp_valid), 32'd0);
    check("single_ack_level", 32'(level), 32'd0);
    check("single_empty_mask", 32'(rsp_mask), 32'd0);

    // Ordering and wrap: ack on odd cycles, levels 1,1,2,2,3,3
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(i + 1), i[0], 3'(i), i[0], 1'b0);
      check("order_overflow", 32'(overflow), 32'd0);
    end
    check("order_level", 32'(level), 32'd3);
    drain("order");

    // Overflow: five writes, no ack
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 3'd1, 1'b0, 1'b0);
      if (i == 2) check("ovf_full_after3", 32'(rtu_full), 32'd0);
      if (i == 3) begin
        check("ovf_full_after4", 32'(rtu_full), 32'd1);
        check("ovf_no_pulse_yet", 32'(overflow), 32'd0);
      end
    end
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check("ovf_pulse_end", 32'(overflow), 32'd0);
`ifdef SWC_RTU_RSP_FIFO_STATS_EN
    check("stats_ovf_cnt", 32'(overflow_cnt), 32'd1);
    check("stats_max_level", 32'(max_level), 32'd4);
`endif
    drain("ovf");

    // Full with simultaneous write and ack
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b1, 3'd7, 1'b0, 1'b0);
    step(1'b1, 8'h15, 1'b0, 3'd2, 1'b1, 1'b0);
    check("fullwa_level", 32'(level), 32'd4);
    check("fullwa_overflow", 32'(overflow), 32'd0);
    check("fullwa_full", 32'(rtu_full), 32'd1);
    check("fullwa_head", 32'(rsp_mask), 32'h12);
    drain("fullwa");

    // Flush beats a same-cycle write and ack
    for (int i = 0; i < 3; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 3'd0, 1'b1, 1'b1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(rsp_valid), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
`ifdef SWC_RTU_RSP_FIFO_STATS_EN
    check("flush_stats_cnt", 32'(overflow_cnt), 32'd0);
`endif
    step(1'b1, 8'h80, 1'b1, 3'd5, 1'b0, 1'b0);
    check("flush_new_valid", 32'(rsp_valid), 32'd1);
    check("flush_new_head", 32'(rsp_mask), 32'h80);
    drain("flush");

    // Asynchronous reset mid-stream
    step(1'b1, 8'h41, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 3'd1, 1'b0, 1'b0);
    check("prerst_level", 32'(level), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full", 32'(rtu_full), 32'd0);
    check("rst_data", 32'({rsp_mask, rsp_drop, rsp_prio}), 32'd0);
    sb_q.delete();
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check("ack_empty_level", 32'(level), 32'd0);
    check("ack_empty_valid", 32'(rsp_valid), 32'd0);

    // Empty with valid+ack: write accepted
    step(1'b1, 8'h51, 1'b0, 3'd6, 1'b1, 1'b0);
    check("empty_va_level", 32'(level), 32'd1);
    check("empty_va_head", 32'(rsp_mask), 32'h51);
    // Single entry with valid+ack: head replaced
    step(1'b1, 8'h52, 1'b1, 3'd4, 1'b1, 1'b0);
    check("single_va_level", 32'(level), 32'd1);
    check("single_va_head", 32'({rsp_mask, rsp_drop, rsp_prio}), 32'({8'h52, 1'b1, 3'd4}));
    drain("tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/swc_rtu_rsp_fifo.md
Name: swc_rtu_rsp_fifo

Overview:
- Per-port buffer for RTU forwarding decisions (destination mask, drop, priority) between the RTU and the switching core's rtu_rsp_valid/ack interface.
- Absorbs RTU decision bursts so the input block can accept a decision later than it is produced.
- One instance per port; the outputs drive rtu_rsp_valid_i, rtu_dst_port_mask_i, rtu_drop_i and rtu_prio_i of the core directly.

Parameters:
- g_num_ports, 8: width of the destination port mask.
- g_prio_width, 3: width of the priority field.
- g_depth, 4: number of entries; power of two, minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset.
- flush_i  in  1  synchronous flush; empties the FIFO.
- rtu_valid_i  in  1  RTU decision strobe; one cycle per decision.
- rtu_dst_port_mask_i  in  g_num_ports  decision destination mask.
- rtu_drop_i  in  1  decision drop flag.
- rtu_prio_i  in  g_prio_width  decision priority.
- rtu_full_o  out  1  FIFO full.
- rsp_valid_o  out  1  head entry valid (to core rtu_rsp_valid_i).
- rsp_ack_i  in  1  core consumed the head entry (from core rtu_rsp_ack_o).
- rsp_dst_port_mask_o  out  g_num_ports  head destination mask.
- rsp_drop_o  out  1  head drop flag.
- rsp_prio_o  out  g_prio_width  head priority.
- level_o  out  log2(g_depth)+1  current entry count.
- overflow_o  out  1  one-cycle pulse when a decision is lost.

Behaviour:
- Clocking and reset:
  - Single clock clk_i.
  - Reset rst_n_i is asynchronous, active-low.
  - Reset values: rd_ptr=0, wr_ptr=0, count=0, rsp_valid_o=0, rtu_full_o=0, level_o=0, overflow_o=0.
  - Storage contents are don't-care after reset; rsp_* data outputs read 0 while the FIFO is empty.
- Storage: register array of g_depth entries, each {mask, drop, prio}. Pointers are log2(g_depth) bits and wrap naturally modulo g_depth.
- Head presentation:
  - First-word-fall-through: rsp_* outputs are driven from mem[rd_ptr].
  - rsp_valid_o = (count != 0), decoded from registered count.
  - Latency: a write into an empty FIFO at edge N gives rsp_valid_o=1 and head data in cycle N+1.
- Write rule:
  - wr_en = rtu_valid_i & (~full | rd_en).
  - full = (count == g_depth).
  - rtu_full_o = full, registered-count based.
- Read rule:
  - rd_en = rsp_ack_i & rsp_valid_o.
  - rsp_ack_i while empty is ignored and causes no pointer change.
- Count update:
  - wr_en only: count+1.
  - rd_en only: count-1.
  - Both or neither: unchanged.
- Back-to-back operation: consecutive acks retire one entry per cycle with no bubble; the next head is visible the cycle after each ack.
- Boundary cases:
  - Full with simultaneous ack and valid: the write is accepted, count stays g_depth, overflow_o=0.
  - Full with valid and no ack: the decision is discarded, overflow_o=1 for exactly one cycle, and state is unchanged.
  - Empty with simultaneous valid and ack: the ack is ignored, the write is accepted, count becomes 1.
  - Single-entry FIFO with simultaneous valid and ack: read and write both occur, count stays 1, and the new entry becomes the head next cycle.
- Flush:
  - flush_i=1 at an edge sets rd_ptr=wr_ptr=0 and count=0.
  - It has priority over a same-cycle write (the write is dropped) and over a same-cycle ack.
  - A write lost to flush_i does not raise overflow_o.
  - rsp_valid_o=0 the next cycle.
- Reset mid-operation: all state clears immediately (asynchronous assertion); the FIFO is empty once rst_n_i deasserts.
- level_o = count.

Optional Feature:
- Macro: SWC_RTU_RSP_FIFO_STATS_EN.
- When defined, the following ports and behaviour are added:
  - overflow_cnt_o, 16 bits: increments on each overflow_o pulse and saturates at 0xFFFF.
  - max_level_o, log2(g_depth)+1 bits: high-water mark of count.
  - Both reset to 0 on rst_n_i and clear on flush_i.
  - Clear has priority over increment in the same cycle.
- When not defined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Single decision: mask=0x05, drop=0, prio=3 in an empty FIFO -> rsp_valid_o=1 the next cycle with the same values; ack -> rsp_valid_o=0 and level_o=0 one cycle later.
- Ordering and wrap: g_depth=4; write 6 decisions with masks 0x01..0x06 while acking every other cycle -> heads appear in order 0x01..0x06, no overflow_o, pointers wrap correctly.
- Overflow: 5 writes with no ack -> rtu_full_o=1 after the 4th write; the 5th write gives overflow_o high one cycle; heads then read 0x01..0x04 (STATS_EN: overflow_cnt_o=1, max_level_o=4).
- Full with simultaneous write and ack: level_o stays 4, overflow_o=0, the new entry is read last.
- Flush: 3 entries stored, then flush_i together with rtu_valid_i -> next cycle level_o=0, rsp_valid_o=0, overflow_o=0, and a subsequent write mask=0x80 is the head.
- Async reset mid-stream with 2 entries stored -> all outputs 0 immediately; ack ignored while empty.
